student_mux: RTL and testbench

//   2:1 multiplexer: forwards data input a or b to out under control of sel.

---
 rtl/student_mux.sv | 41 ++++
 tb/tb_student_mux.sv | 136 +++++++++++++
 2 files changed

// File: rtl/student_mux.sv
// 2:1 multiplexer primitive: forwards a (sel=0) or b (sel=1) to out.
// Combinational by default; REGISTERED=1 adds a single output register with synchronous reset.
module student_mux #(
   parameter int unsigned WIDTH      = 1,
   parameter bit          REGISTERED = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] w_sel_data;

   // Every bit shares the same select; a ternary keeps sel=x propagating as x in simulation.
   assign w_sel_data = sel ? b : a;

   if (REGISTERED) begin : g_reg
      logic [WIDTH-1:0] r_out;

      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_out <= '0;
         end else begin
            r_out <= w_sel_data;
         end
      end

      assign out = r_out;
   end else begin : g_comb
      // clk and rst are deliberately ignored here and may be left floating.
      logic w_unused;
      assign w_unused = ^{clk, rst};

      assign out = w_sel_data;
   end

endmodule

// File: tb/tb_student_mux.sv
// Self-checking bench for student_mux: combinational 1- and 8-bit builds plus the registered build,
// directed cases followed by randomized stimulus scored against a behavioural model.
`timescale 1ns/1ps
module tb_student_mux;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Combinational WIDTH=1 instance; its clock and reset are left floating and never driven.
   logic       c1_clk = 1'bz;
   logic       c1_rst = 1'bz;
   logic       c1_a, c1_b, c1_sel;
   logic       c1_out;

   // Combinational WIDTH=8 instance.
   logic       c8_clk = 1'b0;
   logic       c8_rst = 1'b0;
   logic [7:0] c8_a, c8_b;
   logic       c8_sel;
   logic [7:0] c8_out;

   // Registered WIDTH=8 instance.
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] r8_a, r8_b;
   logic       r8_sel;
   logic [7:0] r8_out;

   student_mux #(.WIDTH(1), .REGISTERED(1'b0)) u_c1 (
      .clk(c1_clk), .rst(c1_rst), .a(c1_a), .b(c1_b), .sel(c1_sel), .out(c1_out)
   );

   student_mux #(.WIDTH(8), .REGISTERED(1'b0)) u_c8 (
      .clk(c8_clk), .rst(c8_rst), .a(c8_a), .b(c8_b), .sel(c8_sel), .out(c8_out)
   );

   student_mux #(.WIDTH(8), .REGISTERED(1'b1)) u_r8 (
      .clk(clk), .rst(rst), .a(r8_a), .b(r8_b), .sel(r8_sel), .out(r8_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference rule, bit by bit: each output bit picks b when sel is set, otherwise a.
   function automatic logic [7:0] ref_mux(input logic [7:0] fa, input logic [7:0] fb, input logic fs);
      logic [7:0] res;
      for (int i = 0; i < 8; i++) res[i] = fs ? fb[i] : fa[i];
      return res;
   endfunction

   // Registered-model state: the value the output must hold after the latest edge.
   logic [7:0] m_out;
   bit         m_valid = 1'b0;

   // One registered cycle: drive at the falling edge, confirm the output still holds, then
   // check the value produced by the next rising edge.
   task automatic reg_cycle(input logic [7:0] ta, input logic [7:0] tb_, input logic ts,
                            input logic tr, input string tag);
      @(negedge clk);
      r8_a = ta; r8_b = tb_; r8_sel = ts; rst = tr;
      #1;
      if (m_valid) check({tag, "_hold"}, r8_out, m_out);
      @(posedge clk);
      m_out   = tr ? 8'h00 : ref_mux(ta, tb_, ts);
      m_valid = 1'b1;
      #1;
      check({tag, "_edge"}, r8_out, m_out);
   endtask

   initial begin
      logic [2:0] combo;
      logic [7:0] ra, rb;
      logic       rs, rr;

      rst = 1'b0; r8_a = '0; r8_b = '0; r8_sel = 1'b0;

      // Exhaustive WIDTH=1 truth table.
      for (int i = 0; i < 8; i++) begin
         combo = 3'(i);
         c1_a = combo[2]; c1_b = combo[1]; c1_sel = combo[0];
         #1;
         check($sformatf("tt_a%0d_b%0d_s%0d", combo[2], combo[1], combo[0]),
               {7'b0, c1_out}, {7'b0, combo[0] ? combo[1] : combo[2]});
      end

      // Floating clk/rst, no clock activity on this instance.
      c1_a = 1'b0; c1_b = 1'b1; c1_sel = 1'b1;
      #1;
      check("float_clk", {7'b0, c1_out}, 8'h01);

      // WIDTH=8 directed patterns.
      c8_a = 8'hA5; c8_b = 8'h3C; c8_sel = 1'b0;
      #1; check("w8_sel0", c8_out, 8'hA5);
      c8_sel = 1'b1;
      #1; check("w8_sel1", c8_out, 8'h3C);

      // WIDTH=8 randomized combinational, with simultaneous changes of all inputs.
      for (int i = 0; i < 40; i++) begin
         c8_a = 8'($urandom); c8_b = 8'($urandom); c8_sel = 1'($urandom);
         #1;
         check("w8_rand", c8_out, ref_mux(c8_a, c8_b, c8_sel));
      end

      // Registered: reset held two cycles with both inputs high.
      reg_cycle(8'hFF, 8'hFF, 1'b1, 1'b1, "rst1");
      reg_cycle(8'hFF, 8'hFF, 1'b1, 1'b1, "rst2");
      // Release: b appears after exactly one edge.
      reg_cycle(8'h00, 8'hFF, 1'b1, 1'b0, "rel");

      // Latency: sel toggles every cycle, out trails it by one edge and holds in between.
      for (int i = 0; i < 8; i++)
         reg_cycle(8'h00, 8'hFF, 1'(i), 1'b0, "tog");

      // Mid-run reset coinciding with a=1, sel=0, then release.
      reg_cycle(8'hFF, 8'h00, 1'b0, 1'b1, "mid_rst");
      reg_cycle(8'hFF, 8'h00, 1'b0, 1'b0, "mid_rel");

      // Randomized registered traffic with occasional resets.
      for (int i = 0; i < 200; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
         rr = ($urandom_range(9) == 0);
         reg_cycle(ra, rb, rs, rr, "rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
